// File: rtl/xadc_pkg.sv
// Shared DRP definitions for the XADC DRP responder: address map, widths and FSM encoding.
package xadc_pkg;

  localparam int unsigned DRP_AW = 7;
  localparam int unsigned DRP_DW = 16;

  // DRP address map
  localparam logic [DRP_AW-1:0] ADDR_VAUX_BASE = 7'h10;
  localparam logic [DRP_AW-1:0] ADDR_VAUX3     = 7'h13;
  localparam logic [DRP_AW-1:0] ADDR_VAUX11    = 7'h1B;
  localparam logic [DRP_AW-1:0] ADDR_CFG_BASE  = 7'h40;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } drp_state_e;

endpackage

// File: rtl/xadc_drp_regfile.sv
// 128 x 16 DRP register space: one config write port, one sample (status) write port,
// asynchronous read. The two write ports target disjoint address ranges, so they never collide.
module xadc_drp_regfile
  import xadc_pkg::*;
#(
  parameter logic [DRP_DW-1:0] RESET_FILL = 16'h0000
) (
  input  logic              clk_35mhz,
  input  logic              reset,
  input  logic              cfg_we_i,
  input  logic [DRP_AW-1:0] cfg_addr_i,
  input  logic [DRP_DW-1:0] cfg_wdata_i,
  input  logic              smp_we_i,
  input  logic [3:0]        smp_chan_i,
  input  logic [11:0]       smp_code_i,
  input  logic [DRP_AW-1:0] rd_addr_i,
  output logic [DRP_DW-1:0] rd_data_o
);

  localparam int unsigned Depth = 1 << DRP_AW;

  logic [DRP_DW-1:0] mem_q [Depth];
  logic [DRP_AW-1:0] smp_addr;

  assign smp_addr = ADDR_VAUX_BASE + {3'b000, smp_chan_i};

  // Storage: reset fill, then config writes and left-justified sample writes
  always_ff @(posedge clk_35mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= RESET_FILL;
      end
    end else begin
      if (cfg_we_i) begin
        mem_q[cfg_addr_i] <= cfg_wdata_i;
      end
      if (smp_we_i) begin
        mem_q[smp_addr] <= {smp_code_i, 4'b0000};
      end
    end
  end

  // Read is combinational so the responder sees pre-update contents in the response cycle
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC DRP responder: stands in for the XADC hard macro on the DRP bus.
// Optional build macro XADC_DRP_JITTER_EN adds 0..3 pseudo-random extra cycles of latency
// per transaction from an 8-bit LFSR. LATENCY must be in 1..15.
module xadc_drp_responder
  import xadc_pkg::*;
#(
  parameter int unsigned       LATENCY    = 4,
  parameter logic [DRP_DW-1:0] RESET_FILL = 16'h0000
) (
  input  logic              clk_35mhz,
  input  logic              reset,
  input  logic [DRP_AW-1:0] daddr_in,
  input  logic              den_in,
  input  logic              dwe_in,
  input  logic [DRP_DW-1:0] di_in,
  output logic [DRP_DW-1:0] do_out,
  output logic              drdy_out,
  input  logic              sample_valid,
  input  logic [3:0]        sample_chan,
  input  logic [11:0]       sample_data,
  output logic              eoc_out,
  output logic              overlap_err
);

  // Counter holds remaining WAIT cycles; 5 bits covers 14 + 3 jitter cycles
  localparam logic [4:0] LoadBase = 5'(LATENCY - 1);

  drp_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        extra;
  logic [4:0]        load_val;
  logic              accept;
  logic              resp;
  logic [DRP_AW-1:0] addr_q;
  logic              we_q;
  logic [DRP_DW-1:0] di_q;
  logic [DRP_DW-1:0] do_q, do_d;
  logic [DRP_DW-1:0] rd_data;
  logic              cfg_we;
  logic              eoc_q;
  logic              ovl_q, ovl_d;

`ifdef XADC_DRP_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps for x^8+x^6+x^5+x^4+1
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR free-runs every cycle from a fixed seed
  always_ff @(posedge clk_35mhz or posedge reset) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign extra = {3'b000, lfsr_q[1:0]};
`else
  assign extra = 5'd0;
`endif

  assign load_val = LoadBase + extra;

  // FSM state and wait counter
  always_ff @(posedge clk_35mhz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: accept in IDLE, count down in WAIT, single response cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (den_in) begin
          accept = 1'b1;
          cnt_d  = load_val;
          state_d = (load_val == 5'd0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 5'd1;
        // Leave on the cycle the count would hit zero so drdy lands LATENCY cycles after accept
        if (cnt_q <= 5'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state; read data is live from the regfile during the response cycle
  always_comb begin
    resp     = (state_q == StResp);
    drdy_out = resp;
    cfg_we   = resp && we_q && (addr_q >= ADDR_CFG_BASE);
    do_d     = (resp && !we_q) ? rd_data : do_q;
    do_out   = do_d;
    ovl_d    = ovl_q | (den_in && (state_q != StIdle));
  end

  // Transaction latch, held read data, sticky overlap flag and end-of-conversion pulse
  always_ff @(posedge clk_35mhz or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      di_q   <= '0;
      do_q   <= '0;
      ovl_q  <= 1'b0;
      eoc_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= daddr_in;
        we_q   <= dwe_in;
        di_q   <= di_in;
      end
      do_q  <= do_d;
      ovl_q <= ovl_d;
      eoc_q <= sample_valid;
    end
  end

  assign overlap_err = ovl_q;
  assign eoc_out     = eoc_q;

  xadc_drp_regfile #(
    .RESET_FILL (RESET_FILL)
  ) u_regfile (
    .clk_35mhz   (clk_35mhz),
    .reset       (reset),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (addr_q),
    .cfg_wdata_i (di_q),
    .smp_we_i    (sample_valid),
    .smp_chan_i  (sample_chan),
    .smp_code_i  (sample_data),
    .rd_addr_i   (addr_q),
    .rd_data_o   (rd_data)
  );

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Self-checking bench for xadc_drp_responder (default build, no jitter).
module tb_xadc_drp_responder;
  import xadc_pkg::*;

  localparam int unsigned LAT = 4;

  logic        clk_35mhz = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  daddr_in = '0;
  logic        den_in = 1'b0;
  logic        dwe_in = 1'b0;
  logic [15:0] di_in = '0;
  logic [15:0] do_out;
  logic        drdy_out;
  logic        sample_valid = 1'b0;
  logic [3:0]  sample_chan = '0;
  logic [11:0] sample_data = '0;
  logic        eoc_out;
  logic        overlap_err;

  always #5 clk_35mhz = ~clk_35mhz;

  xadc_drp_responder #(
    .LATENCY    (LAT),
    .RESET_FILL (16'h0000)
  ) dut (
    .clk_35mhz    (clk_35mhz),
    .reset        (reset),
    .daddr_in     (daddr_in),
    .den_in       (den_in),
    .dwe_in       (dwe_in),
    .di_in        (di_in),
    .do_out       (do_out),
    .drdy_out     (drdy_out),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .sample_data  (sample_data),
    .eoc_out      (eoc_out),
    .overlap_err  (overlap_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          lat;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  logic [15:0] last_do = 16'h0000;

  task automatic tick();
    @(posedge clk_35mhz);
    #1;
  endtask

  task automatic drp_start(input logic [6:0] a, input logic we, input logic [15:0] d);
    daddr_in = a;
    dwe_in   = we;
    di_in    = d;
    den_in   = 1'b1;
    tick();
    den_in = 1'b0;
    dwe_in = 1'b0;
  endtask

  // Returns in the drdy cycle (or after the bound expires with seen=0)
  task automatic wait_drdy(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 40; i++) begin
      if (drdy_out) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Push expectation, drive one transaction, capture do_out at drdy, return to IDLE
  task automatic drp_txn(input logic [6:0] a, input logic we, input logic [15:0] d,
                         input logic [15:0] exp_do, output int lat, output bit seen,
                         output logic [15:0] got);
    sb.push_back('{int'(LAT), exp_do});
    drp_start(a, we, d);
    wait_drdy(lat, seen);
    got = do_out;
    tick();
  endtask

  task automatic inject(input logic [3:0] ch, input logic [11:0] code);
    sample_valid = 1'b1;
    sample_chan  = ch;
    sample_data  = code;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({do_out, drdy_out, eoc_out, overlap_err} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got do=%h drdy=%b eoc=%b ovl=%b required all 0",
               do_out, drdy_out, eoc_out, overlap_err);
    end
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({drdy_out, eoc_out, overlap_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got drdy=%b eoc=%b ovl=%b required 000",
               drdy_out, eoc_out, overlap_err);
    end
  endtask

  task automatic test_sample_read();
    int lat; bit seen; logic [15:0] got; exp_t e;
    inject(4'd3, 12'hABC);
    n_checks++;
    if (eoc_out !== 1'b1) begin
      n_fail++;
      $display("FAIL eoc_pulse: got %b required 1", eoc_out);
    end
    tick();
    n_checks++;
    if (eoc_out !== 1'b0) begin
      n_fail++;
      $display("FAIL eoc_single: got %b required 0", eoc_out);
    end
    drp_txn(ADDR_VAUX3, 1'b0, 16'h0, 16'hABC0, lat, seen, got);
    e = sb.pop_front();
    n_checks++;
    if (!seen || lat != e.lat) begin
      n_fail++;
      $display("FAIL read13_latency: got %0d (seen=%0b) required %0d", lat, seen, e.lat);
    end
    n_checks++;
    if (got !== e.data) begin
      n_fail++;
      $display("FAIL read13_data: got %h required %h", got, e.data);
    end
    last_do = e.data;
  endtask

  // Writes to config space then reads back; write transactions must leave do_out alone
  task automatic test_cfg_write();
    int lat; bit seen; logic [15:0] got; exp_t e;
    logic [6:0]  addrs[5];
    logic [15:0] vals[5];
    addrs[0] = 7'h41;
    vals[0]  = 16'h1234;
    for (int i = 1; i < 5; i++) begin
      addrs[i] = ADDR_CFG_BASE + 7'(i * 13);
      vals[i]  = 16'($urandom);
    end
    for (int i = 0; i < 5; i++) begin
      drp_txn(addrs[i], 1'b1, vals[i], last_do, lat, seen, got);
      e = sb.pop_front();
      n_checks++;
      if (!seen || lat != e.lat || got !== e.data) begin
        n_fail++;
        $display("FAIL cfg_write[%0d]: got lat=%0d seen=%0b do=%h required lat=%0d do=%h",
                 i, lat, seen, got, e.lat, e.data);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drp_txn(addrs[i], 1'b0, 16'h0, vals[i], lat, seen, got);
      e = sb.pop_front();
      n_checks++;
      if (!seen || lat != e.lat || got !== e.data) begin
        n_fail++;
        $display("FAIL cfg_read[%0d]: got lat=%0d seen=%0b do=%h required lat=%0d do=%h",
                 i, lat, seen, got, e.lat, e.data);
      end
      last_do = e.data;
    end
  endtask

  task automatic test_status_write();
    int lat; bit seen; logic [15:0] got; exp_t e;
    drp_txn(ADDR_VAUX11, 1'b1, 16'hFFFF, last_do, lat, seen, got);
    e = sb.pop_front();
    n_checks++;
    if (!seen || got !== e.data) begin
      n_fail++;
      $display("FAIL status_write_drdy: got seen=%0b do=%h required seen=1 do=%h",
               seen, got, e.data);
    end
    drp_txn(ADDR_VAUX11, 1'b0, 16'h0, 16'h0000, lat, seen, got);
    e = sb.pop_front();
    n_checks++;
    if (!seen || got !== e.data) begin
      n_fail++;
      $display("FAIL status_write_discard: got do=%h required %h", got, e.data);
    end
    last_do = e.data;
  endtask

  task automatic test_no_overlap();
    n_checks++;
    if (overlap_err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_overlap: got %b required 0", overlap_err);
    end
  endtask

  task automatic test_held_den();
    int q_off[$];
    int tmp;
    for (int k = int'(LAT); k < 20; k += int'(LAT) + 1) q_off.push_back(k);
    daddr_in = ADDR_VAUX3;
    dwe_in   = 1'b0;
    den_in   = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 19) den_in = 1'b0;
      if (drdy_out) begin
        n_checks++;
        if (q_off.size() == 0 || q_off[0] != k) begin
          n_fail++;
          $display("FAIL held_den_offset: got drdy at offset %0d required %0d", k,
                   (q_off.size() == 0) ? -1 : q_off[0]);
        end
        if (q_off.size() != 0) tmp = q_off.pop_front();
        n_checks++;
        if (do_out !== 16'hABC0) begin
          n_fail++;
          $display("FAIL held_den_data: got %h required abc0", do_out);
        end
      end
    end
    n_checks++;
    if (q_off.size() != 0) begin
      n_fail++;
      $display("FAIL held_den_missing: got %0d pulses missing required 0", q_off.size());
    end
    n_checks++;
    if (overlap_err !== 1'b1) begin
      n_fail++;
      $display("FAIL held_den_overlap: got %b required 1", overlap_err);
    end
    tick();
    last_do = 16'hABC0;
  endtask

  task automatic test_reset_mid();
    int lat; bit seen; logic [15:0] got; exp_t e;
    int pulses = 0;
    drp_start(ADDR_VAUX3, 1'b0, 16'h0);
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({do_out, drdy_out, eoc_out, overlap_err} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got do=%h drdy=%b eoc=%b ovl=%b required all 0",
               do_out, drdy_out, eoc_out, overlap_err);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (drdy_out) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_drdy: got %0d pulses required 0", pulses);
    end
    drp_txn(ADDR_VAUX3, 1'b0, 16'h0, 16'h0000, lat, seen, got);
    e = sb.pop_front();
    n_checks++;
    if (!seen || lat != e.lat || got !== e.data) begin
      n_fail++;
      $display("FAIL reset_mid_fill: got lat=%0d seen=%0b do=%h required lat=%0d do=%h",
               lat, seen, got, e.lat, e.data);
    end
    last_do = e.data;
  endtask

  // Sample lands on the same register in the response cycle of a read
  task automatic test_read_before_write();
    int lat; bit seen; logic [15:0] got; exp_t e;
    inject(4'd11, 12'h111);
    tick();
    sb.push_back('{int'(LAT), 16'h1110});
    drp_start(ADDR_VAUX11, 1'b0, 16'h0);
    wait_drdy(lat, seen);
    sample_valid = 1'b1;
    sample_chan  = 4'd11;
    sample_data  = 12'h800;
    #1;
    e = sb.pop_front();
    n_checks++;
    if (!seen || lat != e.lat || do_out !== e.data) begin
      n_fail++;
      $display("FAIL rbw_resp: got lat=%0d seen=%0b do=%h required lat=%0d do=%h",
               lat, seen, do_out, e.lat, e.data);
    end
    tick();
    sample_valid = 1'b0;
    n_checks++;
    if (do_out !== 16'h1110 || eoc_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rbw_hold: got do=%h eoc=%b required do=1110 eoc=1", do_out, eoc_out);
    end
    drp_txn(ADDR_VAUX11, 1'b0, 16'h0, 16'h8000, lat, seen, got);
    e = sb.pop_front();
    n_checks++;
    if (!seen || got !== e.data) begin
      n_fail++;
      $display("FAIL rbw_after: got do=%h required %h", got, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sample_read();
    test_cfg_write();
    test_status_write();
    test_no_overlap();
    test_held_den();
    test_reset_mid();
    test_read_before_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
